// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Receives a length-prefixed byte stream over valid/ready, assembles big-endian
// 32-bit words, writes them to imem from word address 0 and holds the core in
// reset until the whole image is in place.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// that is verified before the core is released.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, waiting for start, core held
// LEN    | waiting for the length byte L
// DATA   | receiving 4*N payload bytes, one imem write per word
// CHK    | waiting for the checksum byte (LOADER_CHECKSUM_EN only)
// DONE   | image complete, core released
// ERR    | load aborted, core held, partial words stay in imem
module imem_loader #(
    parameter int ADDR_W    = 6,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [7:0]        word_count
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE, S_ERR} state_t;
`endif

    localparam logic [7:0] MAX_W8 = 8'(MAX_WORDS);

    state_t              state_q, state_d;
    logic                rx_ready_q, rx_ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [7:0]          word_count_q, word_count_d;
    logic [7:0]          n_q, n_d;
    logic [1:0]          idx_q, idx_d;
    // Only the first three bytes of a word need storing; the fourth goes
    // straight into wdata.
    logic [23:0]         shift_q, shift_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          chk_q, chk_d;
`endif
    logic                xfer;
    logic                last_byte;

    assign xfer = rx_valid & rx_ready_q;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        word_count_d = word_count_q;
        n_d          = n_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d        = chk_q;
`endif
        last_byte    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d      = S_LEN;
                    word_count_d = 8'd0;
                    idx_d        = 2'd0;
                    shift_d      = 24'd0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d        = 8'd0;
`endif
                end
            end
            S_LEN: begin
                if (xfer) begin
                    if (rx_data == 8'd0 || rx_data > MAX_W8) begin
                        state_d = S_ERR;
                    end else begin
                        n_d     = rx_data;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    shift_d = {shift_q[15:0], rx_data};
                    idx_d   = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ rx_data;
`endif
                    if (idx_q == 2'd3) begin
                        we_d         = 1'b1;
                        wdata_d      = {shift_q, rx_data};
                        waddr_d      = word_count_q[ADDR_W-1:0];
                        word_count_d = word_count_q + 8'd1;
                        last_byte    = (word_count_d == n_q);
                    end
                end
                // Leave only after the final write strobe has been presented.
                if (we_q && word_count_q == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Ready drops on the edge that takes the last payload byte, so the
        // write cycle of the final word accepts nothing further.
        rx_ready_d = (state_d == S_LEN)
`ifdef LOADER_CHECKSUM_EN
                   || (state_d == S_CHK)
`endif
                   || (state_d == S_DATA && !last_byte);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rx_ready_q   <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= 32'd0;
            word_count_q <= 8'd0;
            n_q          <= 8'd0;
            idx_q        <= 2'd0;
            shift_q      <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
            chk_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            rx_ready_q   <= rx_ready_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            word_count_q <= word_count_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

    assign rx_ready   = rx_ready_q;
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign word_count = word_count_q;
    assign cpu_hold   = (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized frames checked against an
// expected image kept in the bench and a log of observed imem writes.
module tb_imem_loader;
    localparam int ADDR_W    = 6;
    localparam int MAX_WORDS = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [7:0]        word_count;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_ready(rx_ready), .we(we), .waddr(waddr),
        .wdata(wdata), .cpu_hold(cpu_hold), .done(done), .err(err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]       exp_words [0:MAX_WORDS-1];
    logic [ADDR_W-1:0] log_addr [$];
    logic [31:0]       log_data [$];

    // Record every imem write seen by the memory.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            log_addr.push_back(waddr);
            log_data.push_back(wdata);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap, output int waited);
        logic acc;
        waited = 0;
        if (gap) begin
            rx_valid = 1'b0;
            step();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        forever begin
            acc = rx_ready;
            step();
            if (acc) break;
            waited++;
            if (waited > 40) begin
                n_tests++;
                n_fail++;
                $error("FAIL byte_timeout observed=no_accept expected=accept byte=%h", b);
                break;
            end
        end
    endtask

    // Load exp_words[0..n-1] as one frame and check writes, timing and release.
    task automatic load(input int n, input bit gapped, input bit hold_start, input bit cs_good);
        int w;
        int stalls;
        logic [7:0] cs;
        stalls = 0;
        cs = 8'd0;
        rx_valid = 1'b0;
        log_addr.delete();
        log_data.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("len_ready", rx_ready, 1'b1);
        chk("len_hold", cpu_hold, 1'b1);
        chk("len_done", done, 1'b0);
        chk("len_err", err, 1'b0);
        chk("len_wc", word_count, 8'd0);
        send_byte(8'(n), gapped, w);
        stalls += w;
        if (hold_start) start = 1'b1;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                cs = cs ^ exp_words[i][31-8*b -: 8];
                send_byte(exp_words[i][31-8*b -: 8], gapped, w);
                stalls += w;
            end
        end
        start = 1'b0;
        chk("last_we", we, 1'b1);
        chk("last_waddr", waddr, 32'(n - 1));
        chk("last_wdata", wdata, exp_words[n-1]);
        chk("rdy_after_last", rx_ready, 1'b0);
        chk("hold_at_last_we", cpu_hold, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        rx_valid = 1'b0;
        step();
        chk("chk_ready", rx_ready, 1'b1);
        chk("chk_hold", cpu_hold, 1'b1);
        send_byte(cs_good ? cs : (cs ^ 8'h03), 1'b0, w);
        rx_valid = 1'b0;
        if (cs_good) begin
            chk("cs_done", done, 1'b1);
            chk("cs_hold", cpu_hold, 1'b0);
        end else begin
            chk("cs_err", err, 1'b1);
            chk("cs_err_hold", cpu_hold, 1'b1);
        end
`else
        // Stale valid with junk data must not be taken.
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        step();
        rx_valid = 1'b0;
        chk("rel_done", done, cs_good);
        chk("rel_hold", cpu_hold, 1'b0);
        chk("rel_err", err, 1'b0);
`endif
        chk("end_wc", word_count, 32'(n));
        chk("end_ready", rx_ready, 1'b0);
        chk("end_we", we, 1'b0);
        if (!gapped) chk("no_stall", stalls, 0);
        chk("we_count", log_addr.size(), n);
        for (int i = 0; i < n && i < log_addr.size(); i++) begin
            chk($sformatf("waddr[%0d]", i), log_addr[i], 32'(i));
            chk($sformatf("wdata[%0d]", i), log_data[i], exp_words[i]);
        end
    endtask

    task automatic bad_len(input logic [7:0] l);
        int w;
        start = 1'b1;
        step();
        start = 1'b0;
        log_addr.delete();
        log_data.delete();
        send_byte(l, 1'b0, w);
        rx_valid = 1'b0;
        chk($sformatf("badlen_%h_err", l), err, 1'b1);
        chk($sformatf("badlen_%h_hold", l), cpu_hold, 1'b1);
        chk($sformatf("badlen_%h_ready", l), rx_ready, 1'b0);
        step();
        chk($sformatf("badlen_%h_nowe", l), log_addr.size(), 0);
        chk($sformatf("badlen_%h_err2", l), err, 1'b1);
    endtask

    task automatic rand_image(input int n);
        for (int i = 0; i < n; i++) exp_words[i] = $urandom;
    endtask

    initial begin
        int w;
        int n;

        // Reset hold.
        reset = 1'b0;
        repeat (3) step();
        chk("rst_hold", cpu_hold, 1'b1);
        chk("rst_ready", rx_ready, 1'b0);
        reset = 1'b1;
        repeat (5) step();
        chk("idle_hold", cpu_hold, 1'b1);
        chk("idle_ready", rx_ready, 1'b0);
        chk("idle_we", we, 1'b0);
        chk("idle_waddr", waddr, 32'd0);
        chk("idle_wdata", wdata, 32'd0);
        chk("idle_done", done, 1'b0);
        chk("idle_err", err, 1'b0);
        chk("idle_wc", word_count, 8'd0);
        chk("idle_no_we", log_addr.size(), 0);

        // Two-word image, back-to-back then gapped.
        exp_words[0] = 32'h2008_0005;
        exp_words[1] = 32'hAC08_0000;
        load(2, 1'b0, 1'b0, 1'b1);
        load(2, 1'b1, 1'b0, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        load(2, 1'b0, 1'b0, 1'b0);
`endif

        // Bad lengths, then recovery with a valid frame.
        bad_len(8'h00);
        bad_len(8'(MAX_WORDS + 1));
        rand_image(3);
        load(3, 1'b0, 1'b0, 1'b1);

        // Randomized frames; start held during one payload must be ignored.
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 8);
            rand_image(n);
            load(n, 1'($urandom_range(0, 1)), k == 2, 1'b1);
        end

        // Largest accepted image.
        rand_image(MAX_WORDS);
        load(MAX_WORDS, 1'b0, 1'b0, 1'b1);

        // Mid-frame reset after 6 payload bytes.
        start = 1'b1;
        step();
        start = 1'b0;
        send_byte(8'd2, 1'b0, w);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0, w);
        rx_valid = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mid_rst_wc", word_count, 8'd0);
        chk("mid_rst_hold", cpu_hold, 1'b1);
        chk("mid_rst_ready", rx_ready, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_err", err, 1'b0);
        chk("mid_rst_we", we, 1'b0);
        step();
        chk("mid_rst_idle_ready", rx_ready, 1'b0);

        // Reload from DONE with a fresh one-word image at address 0.
        rand_image(3);
        load(3, 1'b0, 1'b0, 1'b1);
        rand_image(1);
        load(1, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
